output_unit_credit_ctrl: RTL and testbench
==========================================

// Module: output_unit_credit_ctrl
// PURPOSE
//  Upstream end of the router's credit-based link, one instance per output port.
//  Holds the credit count for the downstream input FIFO and drives credit_avail to the input units.
//  Consumes the switch-grant decrement and the credit pulses returned by the downstream node.
//  Registers the switch-traversal flit onto the outgoing link.
//  Flags credit protocol violations.
// PARAMETERS
//  DATA_WIDTH  36  flit width (info[35:32], addr[31:16], payload[15:0])
//  BUF_DEPTH   4   downstream input FIFO depth = credits held after reset (>=1)
//  CNT_WIDTH   $clog2(BUF_DEPTH+1)  credit counter width
// PORTS
//  clk            in   1           system clock
//  rst            in   1           reset, asynchronous, active-high
//  credit_decre   in   1           OR of input units' out_credit_decre bit for this port (switch grant)
//  credit_in      in   1           credit return pulse from downstream input unit, 1 per freed slot
//  st_valid       in   1           crossbar output valid for this port (st_ctrl_in bit)
//  st_data        in   DATA_WIDTH  crossbar output flit
//  credit_avail   out  1           this port has >=1 credit and controller is in RUN
//  credit_count   out  CNT_WIDTH   current credit count
//  out_valid      out  1           link flit valid (downstream in_data_valid)
//  out_data       out  DATA_WIDTH  link flit
//  err_underflow  out  1           sticky: decrement with zero credits
//  err_overflow   out  1           sticky: credit returned beyond BUF_DEPTH
//  err_orphan     out  1           sticky: st_valid without decrement in the previous cycle
// BEHAVIOUR
//  Reset values:
//   - state=INIT, credit_count=BUF_DEPTH, credit_avail=0.
//   - out_valid=0, out_data=0, all err_*=0, pending=0.
//   - rst asserted mid-operation discards in-flight flits and pending credits immediately.
//  FSM:
//   - INIT: lasts exactly one cycle after rst deasserts, then RUN.
//   - RUN: normal operation.
//   - ERR: entered the cycle after any err_* sets; held until rst.
//  credit_avail = (state==RUN) && (credit_count!=0).
//   - Combinational from registered state/count only; never from the same-cycle credit_in or decre.
//  Counter update, every state, one cycle latency:
//   - decre & credit_in: count unchanged (net zero), no error.
//   - decre only: count>0 -> count-1; count==0 -> stays 0, err_underflow<=1.
//   - credit_in only: count<BUF_DEPTH -> count+1; count==BUF_DEPTH -> saturates, err_overflow<=1.
//   - Arithmetic is unsigned in CNT_WIDTH bits; count never wraps.
//  Link register, 1-cycle latency:
//   - out_valid<=st_valid; out_data<=st_valid ? st_data : 0.
//   - Flits are forwarded in every state, including ERR.
//   - Back-to-back flits on consecutive cycles are forwarded unmodified.
//  Orphan check:
//   - pending<=credit_decre each cycle (the input unit registers ST one cycle after grant).
//   - st_valid && !pending -> err_orphan<=1.
//  ERR: credit_avail forced 0; counter keeps tracking; err_* remain set until rst.
//  At most one decrement per cycle (switch arbiter grants one input per output).
// TESTING
//  1. Reset, then idle 3 cycles -> credit_avail 0 in INIT cycle, 1 from 2nd cycle, credit_count=4.
//  2. 4 decre pulses on consecutive cycles, no credit_in
//     -> count 3,2,1,0; credit_avail 0 after 4th; out_valid follows st_valid one cycle later.
//  3. At count=0, pulse decre and credit_in together -> count stays 0, no error.
//     Then credit_in alone -> count=1, credit_avail=1.
//  4. At count=4, pulse credit_in -> count stays 4, err_overflow=1; next cycle state ERR, credit_avail=0.
//  5. At count=0, pulse decre alone -> err_underflow=1, count=0.
//     st_valid with no prior decre -> err_orphan=1.
//  6. Assert rst mid-stream with count=1 and st_valid high
//     -> out_valid=0, count=4, err_*=0 immediately; INIT, then RUN.

Source files
------------

// File: rtl/output_unit_credit_ctrl.sv
// Upstream credit controller for one router output port: tracks downstream FIFO credits,
// registers the switch-traversal flit onto the link and flags credit protocol violations.
module output_unit_credit_ctrl #(
   parameter int unsigned DATA_WIDTH = 36,
   parameter int unsigned BUF_DEPTH  = 4,
   parameter int unsigned CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  credit_decre,
   input  logic                  credit_in,
   input  logic                  st_valid,
   input  logic [DATA_WIDTH-1:0] st_data,
   output logic                  credit_avail,
   output logic [CNT_WIDTH-1:0]  credit_count,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  err_underflow,
   output logic                  err_overflow,
   output logic                  err_orphan
);

   typedef enum logic [1:0] {
      StInit,
      StRun,
      StErr
   } state_e;

   localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(BUF_DEPTH);
   localparam logic [CNT_WIDTH-1:0] OneCnt = CNT_WIDTH'(1);

   state_e                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    pending_q, pending_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    err_uf_q, err_uf_d;
   logic                    err_of_q, err_of_d;
   logic                    err_orph_q, err_orph_d;

   always_comb begin
      cnt_d       = cnt_q;
      err_uf_d    = err_uf_q;
      err_of_d    = err_of_q;
      err_orph_d  = err_orph_q;
      pending_d   = credit_decre;
      out_valid_d = st_valid;
      out_data_d  = st_valid ? st_data : '0;

      // Simultaneous decrement and return cancel out, so only the lone cases move the count.
      case ({credit_decre, credit_in})
         2'b10: begin
            if (cnt_q == '0) err_uf_d = 1'b1;
            else             cnt_d    = cnt_q - OneCnt;
         end
         2'b01: begin
            if (cnt_q == MaxCnt) err_of_d = 1'b1;
            else                 cnt_d    = cnt_q + OneCnt;
         end
         default: ;
      endcase

      // The input unit drives ST one cycle after its grant, so a flit needs last cycle's decre.
      if (st_valid && !pending_q) err_orph_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StInit:  state_d = StRun;
         StRun:   state_d = StRun;
         StErr:   state_d = StErr;
         default: state_d = StErr;
      endcase
      if (err_uf_q || err_of_q || err_orph_q) state_d = StErr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StInit;
         cnt_q       <= MaxCnt;
         pending_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_uf_q    <= 1'b0;
         err_of_q    <= 1'b0;
         err_orph_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_uf_q    <= err_uf_d;
         err_of_q    <= err_of_d;
         err_orph_q  <= err_orph_d;
      end
   end

   assign credit_avail  = (state_q == StRun) && (cnt_q != '0);
   assign credit_count  = cnt_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign err_underflow = err_uf_q;
   assign err_overflow  = err_of_q;
   assign err_orphan    = err_orph_q;

endmodule

// File: tb/tb_output_unit_credit_ctrl.sv
// Scoreboard bench: directed steps push expected status and link flits; negedge monitors
// pop and compare against the DUT outputs.
module tb_output_unit_credit_ctrl;

   localparam int DW = 36;
   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          credit_decre;
   logic          credit_in;
   logic          st_valid;
   logic [DW-1:0] st_data;
   logic          credit_avail;
   logic [CW-1:0] credit_count;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          err_underflow;
   logic          err_overflow;
   logic          err_orphan;

   output_unit_credit_ctrl #(
      .DATA_WIDTH (DW),
      .BUF_DEPTH  (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .credit_decre  (credit_decre),
      .credit_in     (credit_in),
      .st_valid      (st_valid),
      .st_data       (st_data),
      .credit_avail  (credit_avail),
      .credit_count  (credit_count),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .err_underflow (err_underflow),
      .err_overflow  (err_overflow),
      .err_orphan    (err_orphan)
   );

   typedef struct {
      int         cyc;
      string      name;
      int         cnt;
      int         avail;  // -1: don't care
      logic [2:0] err;    // {underflow, overflow, orphan}
      int         ov;     // -1: don't care
   } stat_t;

   typedef struct {
      int          cyc;
      logic [DW-1:0] data;
   } flit_t;

   stat_t sq[$];
   flit_t fq[$];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_st(input string n, input int c, input int a, input logic [2:0] e,
                            input int ov);
      stat_t s;
      s.cyc = cyc; s.name = n; s.cnt = c; s.avail = a; s.err = e; s.ov = ov;
      sq.push_back(s);
   endtask

   task automatic step(input bit d, input bit c, input bit s, input logic [DW-1:0] dat);
      flit_t f;
      credit_decre = d;
      credit_in    = c;
      st_valid     = s;
      st_data      = dat;
      if (s) begin
         f.cyc = cyc + 1; f.data = dat;
         fq.push_back(f);
      end
      @(posedge clk);
      #1;
   endtask

   // Status monitor
   always @(negedge clk) begin
      stat_t e;
      logic  ok;
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
         e = sq.pop_front();
         total++;
         ok = (e.cyc == cyc) && (credit_count === 3'(e.cnt))
              && (e.avail < 0 || credit_avail === e.avail[0])
              && ({err_underflow, err_overflow, err_orphan} === e.err)
              && (e.ov < 0 || out_valid === e.ov[0]);
         if (!ok) begin
            bad++;
            $display("FAIL %s: cyc=%0d/%0d got cnt=%0d avail=%b err=%b ov=%b, want cnt=%0d avail=%0d err=%b ov=%0d",
                     e.name, cyc, e.cyc, credit_count, credit_avail,
                     {err_underflow, err_overflow, err_orphan}, out_valid,
                     e.cnt, e.avail, e.err, e.ov);
         end
      end
   end

   // Link monitor
   always @(negedge clk) begin
      flit_t f;
      if (out_valid === 1'b1) begin
         total++;
         if (fq.size() == 0) begin
            bad++;
            $display("FAIL flit_unexpected: got data=%h at cyc %0d, want no flit", out_data, cyc);
         end else begin
            f = fq.pop_front();
            if (f.cyc != cyc || out_data !== f.data) begin
               bad++;
               $display("FAIL flit: got data=%h at cyc %0d, want data=%h at cyc %0d",
                        out_data, cyc, f.data, f.cyc);
            end
         end
      end else if (!rst && out_data !== '0) begin
         total++;
         bad++;
         $display("FAIL idle_data: got %h with out_valid=0, want 0", out_data);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, want self-termination");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; credit_decre = 0; credit_in = 0; st_valid = 0; st_data = '0;
      repeat (2) @(posedge clk);
      #1;
      expect_st("rst_state", 4, 0, 3'b000, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Test 1: INIT then RUN
      expect_st("init_cycle", 4, 0, 3'b000, 0);
      step(0, 0, 0, '0); expect_st("run_1", 4, 1, 3'b000, 0);
      step(0, 0, 0, '0); expect_st("run_2", 4, 1, 3'b000, 0);
      // Test 2: four grants, flits one cycle behind each
      step(1, 0, 0, '0);             expect_st("decre_3", 3, 1, 3'b000, 0);
      step(1, 0, 1, 36'h1_1111_0001); expect_st("decre_2", 2, 1, 3'b000, 1);
      step(1, 0, 1, 36'h2_2222_0002); expect_st("decre_1", 1, 1, 3'b000, 1);
      step(1, 0, 1, 36'hF_FFFF_FFFF); expect_st("decre_0", 0, 0, 3'b000, 1);
      step(0, 0, 1, 36'h0_0000_0001); expect_st("last_flit", 0, 0, 3'b000, 1);
      // Test 3: net-zero at empty, then a return
      step(1, 1, 0, '0); expect_st("net_zero", 0, 0, 3'b000, 0);
      step(0, 1, 0, '0); expect_st("return_1", 1, 1, 3'b000, 0);
      step(0, 1, 0, '0); expect_st("return_2", 2, 1, 3'b000, 0);
      step(0, 1, 0, '0); expect_st("return_3", 3, 1, 3'b000, 0);
      step(0, 1, 0, '0); expect_st("return_4", 4, 1, 3'b000, 0);
      // Test 4: overflow, then ERR
      step(0, 1, 0, '0); expect_st("overflow", 4, -1, 3'b010, 0);
      step(0, 0, 0, '0); expect_st("err_state", 4, 0, 3'b010, 0);
      // Test 5: counter tracks in ERR, underflow, orphan
      step(1, 0, 0, '0); expect_st("err_trk_3", 3, 0, 3'b010, 0);
      step(1, 0, 0, '0); expect_st("err_trk_2", 2, 0, 3'b010, 0);
      step(1, 0, 0, '0); expect_st("err_trk_1", 1, 0, 3'b010, 0);
      step(1, 0, 0, '0); expect_st("err_trk_0", 0, 0, 3'b010, 0);
      step(1, 0, 0, '0); expect_st("underflow", 0, 0, 3'b110, 0);
      step(0, 0, 0, '0); expect_st("no_orphan", 0, 0, 3'b110, 0);
      step(0, 0, 1, 36'h5_A5A5_5A5A); expect_st("orphan", 0, 0, 3'b111, 1);
      step(0, 0, 0, '0); expect_st("err_hold", 0, 0, 3'b111, 0);
      // Test 6: async reset with count=1 and a flit on the link
      credit_decre = 0; credit_in = 1; st_valid = 1; st_data = 36'h7_7777_7777;
      @(posedge clk);
      #1;
      credit_in = 0; st_data = 36'h8_8888_8888; rst = 1'b1;
      #1;
      expect_st("rst_async", 4, 0, 3'b000, 0);
      @(posedge clk);
      #1;
      st_valid = 0; st_data = '0; rst = 1'b0;
      expect_st("init_again", 4, 0, 3'b000, 0);
      step(0, 0, 0, '0);             expect_st("run_again", 4, 1, 3'b000, 0);
      step(1, 0, 0, '0);             expect_st("post_decre", 3, 1, 3'b000, 0);
      step(0, 0, 1, 36'hC_0DE0_BEEF); expect_st("post_flit", 3, 1, 3'b000, 1);
      step(0, 0, 0, '0);             expect_st("post_idle", 3, 1, 3'b000, 0);
      step(0, 1, 0, '0);             expect_st("post_return", 4, 1, 3'b000, 0);
      repeat (3) step(0, 0, 0, '0);
      total++;
      if (sq.size() != 0 || fq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d status and %0d flits pending, want 0 and 0",
                  sq.size(), fq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
